// File: rtl/usr_pkg.sv
// Shared mode codes and rotate-engine state encoding for the universal shift register.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_ROTL = 3'b001;
    localparam logic [2:0] MODE_ROTR = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_SHL  = 3'b100;
    localparam logic [2:0] MODE_SHR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_ROTN = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/usr_step_ctrl.sv
// Rotate-by-N sequencer: counts down the requested amount, one single-bit step per cycle,
// then spends one cycle in FIN to flag completion.
module usr_step_ctrl
    import usr_pkg::*;
#(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] amt,
    output logic          busy,
    output logic          done,
    output logic          step_en
);

    state_t        state, state_nx;
    logic [AW-1:0] cnt, cnt_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    // A zero amount skips RUN entirely but still reports completion.
                    if (amt != '0) begin
                        state_nx = ST_RUN;
                        cnt_nx   = amt;
                    end else begin
                        state_nx = ST_FIN;
                    end
                end
            end
            ST_RUN: begin
                cnt_nx = cnt - 1'b1;
                if (cnt == AW'(1)) begin
                    state_nx = ST_FIN;
                end
            end
            ST_FIN:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy    = (state == ST_RUN);
    assign done    = (state == ST_FIN);
    assign step_en = (state == ST_RUN);

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift/rotate register with tri-state bus output and a multi-cycle
// rotate-left-by-AMT command sequenced by usr_step_ctrl.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [2:0]       S,
    input  logic [WIDTH-1:0] D,
    input  logic             SIL,
    input  logic             SIR,
    input  logic [AW-1:0]    AMT,
    input  logic             OE,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QQ,
    output logic             SOL,
    output logic             SOR,
    output logic             BUSY,
    output logic             DONE
);

    logic             idle;
    logic             start;
    logic             step_en;
    logic [WIDTH-1:0] qq_nx;

    // Mode select is only honoured while the rotate engine is idle.
    assign idle  = !BUSY && !DONE;
    assign start = idle && (S == MODE_ROTN);

    usr_step_ctrl #(
        .AW(AW)
    ) u_step_ctrl (
        .clk    (CLK),
        .rst    (RST),
        .start  (start),
        .amt    (AMT),
        .busy   (BUSY),
        .done   (DONE),
        .step_en(step_en)
    );

    always_comb begin
        qq_nx = QQ;
        if (step_en) begin
            qq_nx = {QQ[WIDTH-2:0], QQ[WIDTH-1]};
        end else if (idle) begin
            case (S)
                MODE_HOLD: qq_nx = QQ;
                MODE_ROTL: qq_nx = {QQ[WIDTH-2:0], QQ[WIDTH-1]};
                MODE_ROTR: qq_nx = {QQ[0], QQ[WIDTH-1:1]};
                MODE_LOAD: qq_nx = D;
                MODE_SHL:  qq_nx = {QQ[WIDTH-2:0], SIL};
                MODE_SHR:  qq_nx = {SIR, QQ[WIDTH-1:1]};
                MODE_ASR:  qq_nx = {QQ[WIDTH-1], QQ[WIDTH-1:1]};
                MODE_ROTN: qq_nx = QQ;
                default:   qq_nx = QQ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            QQ <= '0;
        end else begin
            QQ <= qq_nx;
        end
    end

    assign Q   = OE ? {WIDTH{1'bz}} : QQ;
    assign SOL = QQ[WIDTH-1];
    assign SOR = QQ[0];

endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised universal shift/rotate register with a tri-state output bus and a multi-cycle rotate-by-N engine. It is the generalised successor of the team's 4-bit bidirectional rotate register: width is configurable, serial shifts and arithmetic shift are added, and it has a handshaked rotate-by-amount command. It sits on a datapath register bank and drives the shared bus through `Q` under `OE`.

## Interface
- `WIDTH`, 8: register width in bits; must be ≥ 2.
- `AW`, `$clog2(WIDTH)`: width of the rotate amount (derived; do not override).

- `CLK` in 1: single clock, all state updates on rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `S` in 3: mode select, sampled every edge while idle.
- `D` in WIDTH: parallel load data.
- `SIL` in 1: serial input for shift-left, entering bit 0.
- `SIR` in 1: serial input for shift-right, entering bit WIDTH-1.
- `AMT` in AW: rotate amount for mode 111, sampled with the command.
- `OE` in 1: output disable; 1 = `Q` high-Z, 0 = `Q` drives `QQ`.
- `Q` out WIDTH: tri-state bus output.
- `QQ` out WIDTH: internal register, always driven.
- `SOL` out 1: `QQ[WIDTH-1]`, combinational.
- `SOR` out 1: `QQ[0]`, combinational.
- `BUSY` out 1: multi-step rotate in progress.
- `DONE` out 1: one-cycle pulse when a multi-step rotate completes.

## Operation
- Reset (`RST`=1 at an edge): `QQ`=0, FSM=IDLE, step counter=0, `BUSY`=0, `DONE`=0. `RST` overrides every mode, including a rotate in progress. `Q` follows `OE` combinationally at all times, including during reset.
- In IDLE, `S` selects the action at each edge:
  - 000: hold.
  - 001: rotate left, `QQ[i]<=QQ[i-1]`, `QQ[0]<=QQ[WIDTH-1]`.
  - 010: rotate right, `QQ[i]<=QQ[i+1]`, `QQ[WIDTH-1]<=QQ[0]`.
  - 011: parallel load, `QQ<=D`.
  - 100: shift left, `SIL` enters bit 0.
  - 101: shift right, `SIR` enters the MSB.
  - 110: arithmetic shift right, MSB replicated.
  - 111: start multi-step rotate-left by `AMT`.
- FSM states are IDLE, RUN and FIN:
  - IDLE to RUN on `S`=111 with `AMT`≠0; the counter loads `AMT` and `QQ` is unchanged at this edge.
  - IDLE to FIN on `S`=111 with `AMT`=0; `QQ` is unchanged.
  - RUN: each edge rotates `QQ` left by 1 and decrements the counter. When the counter is 1, go to FIN.
  - FIN: lasts one cycle, then goes to IDLE.
- `BUSY`=(state==RUN) and `DONE`=(state==FIN); both are registered state decodes.
- `S`, `D` and `AMT` are ignored in RUN and FIN. A new command is accepted at the first edge where the state is IDLE.
- The rotate executes exactly `AMT` single-bit steps, so the result equals rotate-left by `AMT` mod `WIDTH`. For non-power-of-2 `WIDTH`, values of `AMT` ≥ `WIDTH` are legal.

## Timing
- Single-step modes: result is visible in `QQ` one edge after `S` is sampled; throughput is 1 operation per cycle.
- Rotate by k>0 issued at edge t0:
  - `BUSY` is 1 after t0 through t(k-1), and falls after edge tk.
  - Rotations occur at edges t1..tk.
  - `DONE` is 1 for the cycle after tk.
  - The next command is accepted at edge t(k+2).
  - Total latency from command to final `QQ` is k edges.
- Rotate by 0 at t0: `DONE` is 1 for the cycle after t0 with `BUSY` never asserted; the next command is accepted at t2.
- `Q`, `SOL` and `SOR` are combinational from `OE`/`QQ` with zero-cycle latency.

## Structure
- Package `usr_pkg` holds the mode localparams `MODE_HOLD` … `MODE_ROTN` (3-bit) and the FSM state encoding `ST_IDLE`, `ST_RUN`, `ST_FIN`.
- One sub-module, `usr_step_ctrl`: the FSM plus the AW-bit down-counter. Its interface is `start`, `amt` in; `busy`, `done`, `step_en` out.
- The top level holds the `QQ` datapath mux and the tri-state assignment.

## Test plan
- Reset/OE: `RST`=1 for one edge with `OE`=0 gives `QQ`=`Q`=8'h00, `BUSY`=`DONE`=0. Setting `OE`=1 gives `Q`=8'hZZ while `QQ` is unchanged.
- Load and rotate: load 8'h81 (`S`=011), then `S`=001 gives 8'h03. Then `S`=010 twice gives 8'h81, then 8'hC0.
- Serial and arithmetic shifts:
  - From 8'h96, `S`=100 with `SIL`=1 gives 8'h2D.
  - From 8'h96, `S`=101 with `SIR`=0 gives 8'h4B.
  - From 8'h96, `S`=110 gives 8'hCB.
  - `SOL`/`SOR` match `QQ` MSB/LSB each cycle.
- Multi-step rotate: load 8'h01, `S`=111 with `AMT`=3 at t0. Expect `BUSY` high for 3 cycles, `QQ` stepping 8'h02, 8'h04, 8'h08, `DONE` pulsing once after t3, and `S`=011 held throughout ignored until IDLE.
- `AMT`=0 command: `DONE` pulses one cycle later, `BUSY` stays 0, `QQ` is unchanged.
- Reset mid-rotate: `AMT`=5, assert `RST` at t2. Expect `QQ`=8'h00, state IDLE, `BUSY`=0, no `DONE` pulse, and a new load accepted at t3.
